// File: rtl/ga_mutation_algo_pkg.sv
// Shared GA constants and the mutation-stage FSM state type.
package ga_mutation_algo_pkg;

    localparam int unsigned GA_DATA_W      = 8;
    localparam int unsigned GA_M_MAX       = 20;
    localparam int unsigned GA_M_MAX_W     = 5;
    localparam int unsigned GA_M_IDX_MAX_W = 5;
    localparam int unsigned GA_SIM_DLY     = 1;

    typedef enum logic [1:0] {
        StIdle,
        StMutate,
        StOut
    } ga_mut_state_t;

endpackage

// File: rtl/ga_mutation_idx_gen.sv
// Pseudo-modulus index: pass if below modulus, subtract once, else clamp to modulus-1.
module ga_mutation_idx_gen #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] rnd,
    input  logic [W:0]   modulus,
    output logic [W-1:0] idx
);

    logic [W-1:0] diff;

    // The subtraction path is only taken when rnd >= modulus, so modulus fits in W bits there.
    always_comb begin
        diff = rnd - modulus[W-1:0];
        if ({1'b0, rnd} < modulus) begin
            idx = rnd;
        end else if ({1'b0, diff} < modulus) begin
            idx = diff;
        end else begin
            idx = modulus[W-1:0] - 1'b1;
        end
    end

endmodule

// File: rtl/ga_mutation_algo.sv
// GA mutation stage: accepts a child, applies N random single-bit flip attempts,
// then presents the mutant downstream with a valid/ack handshake.
module ga_mutation_algo
    import ga_mutation_algo_pkg::*;
#(
    parameter int unsigned DATA_W      = GA_DATA_W,
    parameter int unsigned M_MAX       = GA_M_MAX,
    parameter int unsigned M_MAX_W     = GA_M_MAX_W,
    parameter int unsigned M_IDX_MAX_W = GA_M_IDX_MAX_W,
    parameter int unsigned MUT_NUM_W   = 4,
    localparam int unsigned DATA_IDX_W = $clog2(DATA_W),
    localparam int unsigned RAND_W     = M_IDX_MAX_W + DATA_IDX_W + 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sw_rst,
    input  logic [M_MAX_W-1:0]             cnfg_m,
    input  logic [MUT_NUM_W-1:0]           cnfg_mut_num,
    input  logic [7:0]                     cnfg_mut_prob,
    input  logic [RAND_W-1:0]              rand_data,
    input  logic                           child_valid,
    input  logic [M_MAX-1:0][DATA_W-1:0]   child_ary,
    output logic                           child_ack,
    output logic                           mutant_valid,
    output logic [M_MAX-1:0][DATA_W-1:0]   mutant_ary,
    input  logic                           mutant_ack
);

    ga_mut_state_t state_q, state_d;

    logic [M_MAX-1:0][DATA_W-1:0] buf_q, buf_d, mut_ary_q;
    logic [MUT_NUM_W-1:0]         cnt_q, cnt_d, num_lat_q;
    logic [M_MAX_W-1:0]           m_lat_q;
    logic [7:0]                   prob_lat_q;

    logic [M_IDX_MAX_W-1:0] r_elem, elem_idx;
    logic [DATA_IDX_W-1:0]  r_bit, bit_idx;
    logic [7:0]             r_prob;
    logic                   flip, last_attempt, load_out;

    assign r_elem = rand_data[M_IDX_MAX_W-1:0];
    assign r_bit  = rand_data[M_IDX_MAX_W +: DATA_IDX_W];
    assign r_prob = rand_data[RAND_W-1 -: 8];

    ga_mutation_idx_gen #(
        .W (M_IDX_MAX_W)
    ) u_elem_idx (
        .rnd     (r_elem),
        .modulus ((M_IDX_MAX_W+1)'(m_lat_q)),
        .idx     (elem_idx)
    );

    ga_mutation_idx_gen #(
        .W (DATA_IDX_W)
    ) u_bit_idx (
        .rnd     (r_bit),
        .modulus ((DATA_IDX_W+1)'(DATA_W)),
        .idx     (bit_idx)
    );

    assign flip         = (m_lat_q != '0) && (r_prob < prob_lat_q);
    assign last_attempt = (state_q == StMutate) && (cnt_q == num_lat_q - 1'b1);

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else if (sw_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (child_ack) begin
                    state_d = (cnfg_mut_num != '0) ? StMutate : StOut;
                end
            end
            StMutate: begin
                if (last_attempt) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (mutant_ack) begin
                    if (child_ack) begin
                        state_d = (cnfg_mut_num != '0) ? StMutate : StOut;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        child_ack    = child_valid &
                       ((state_q == StIdle) | ((state_q == StOut) & mutant_ack));
        mutant_valid = (state_q == StOut);
        mutant_ary   = mut_ary_q;
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (child_ack) begin
            buf_d = child_ary;
            cnt_d = '0;
        end else if (state_q == StMutate) begin
            cnt_d = cnt_q + 1'b1;
            if (flip) begin
                // Indices at or beyond M_MAX (cnfg_m > M_MAX) match no element.
                for (int i = 0; i < M_MAX; i++) begin
                    if (int'(elem_idx) == i) begin
                        buf_d[i][bit_idx] = ~buf_q[i][bit_idx];
                    end
                end
            end
        end
    end

    // Capture on entry to OUT, including a back-to-back accept with zero attempts.
    assign load_out = (state_d == StOut) && ((state_q != StOut) || child_ack);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q      <= '0;
            mut_ary_q  <= '0;
            cnt_q      <= '0;
            num_lat_q  <= '0;
            m_lat_q    <= '0;
            prob_lat_q <= '0;
        end else if (sw_rst) begin
            buf_q      <= '0;
            mut_ary_q  <= '0;
            cnt_q      <= '0;
            num_lat_q  <= '0;
            m_lat_q    <= '0;
            prob_lat_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            if (child_ack) begin
                num_lat_q  <= cnfg_mut_num;
                m_lat_q    <= cnfg_m;
                prob_lat_q <= cnfg_mut_prob;
            end
            if (load_out) begin
                mut_ary_q <= buf_d;
            end
        end
    end

endmodule

// File: tb/tb_ga_mutation_algo.sv
// Directed bench for ga_mutation_algo with a transaction-level reference model.
module tb_ga_mutation_algo;

    logic              clk = 1'b0;
    logic              rstn;
    logic              sw_rst;
    logic [4:0]        cnfg_m;
    logic [3:0]        cnfg_mut_num;
    logic [7:0]        cnfg_mut_prob;
    logic [15:0]       rand_data;
    logic              child_valid;
    logic [19:0][7:0]  child_ary;
    logic              child_ack;
    logic              mutant_valid;
    logic [19:0][7:0]  mutant_ary;
    logic              mutant_ack;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    // Reference model state
    int               m_left = 0;
    bit               m_out = 1'b0;
    bit               ary_known = 1'b0;
    int               m_m = 0;
    int               m_prob = 0;
    logic [19:0][7:0] m_buf = '0;
    logic [19:0][7:0] exp_ary = '0;

    ga_mutation_algo u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .sw_rst        (sw_rst),
        .cnfg_m        (cnfg_m),
        .cnfg_mut_num  (cnfg_mut_num),
        .cnfg_mut_prob (cnfg_mut_prob),
        .rand_data     (rand_data),
        .child_valid   (child_valid),
        .child_ary     (child_ary),
        .child_ack     (child_ack),
        .mutant_valid  (mutant_valid),
        .mutant_ary    (mutant_ary),
        .mutant_ack    (mutant_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int pm(input int r, input int m);
        if (r < m) return r;
        if (r - m < m) return r - m;
        return m - 1;
    endfunction

    function automatic bit model_accepts();
        return child_valid && ((m_left == 0 && !m_out) || (m_out && mutant_ack));
    endfunction

    always @(posedge clk) begin
        int e, b;
        bit acc;
        if (!rstn || sw_rst) begin
            m_left = 0; m_out = 1'b0; m_m = 0; m_prob = 0;
            m_buf = '0; exp_ary = '0; ary_known = 1'b1;
        end else begin
            acc = model_accepts();
            if (m_left > 0) begin
                e = pm(int'(rand_data[4:0]), m_m);
                b = pm(int'(rand_data[7:5]), 8);
                if (m_m != 0 && int'(rand_data[15:8]) < m_prob && e < 20)
                    m_buf[e][b] = ~m_buf[e][b];
                m_left--;
                if (m_left == 0) begin
                    m_out = 1'b1; exp_ary = m_buf; ary_known = 1'b1;
                end
            end else if (m_out && mutant_ack) begin
                m_out = 1'b0; ary_known = 1'b0;
            end
            if (acc) begin
                m_buf = child_ary; m_m = int'(cnfg_m); m_prob = int'(cnfg_mut_prob);
                m_left = int'(cnfg_mut_num);
                if (cnfg_mut_num == 4'd0) begin
                    m_out = 1'b1; exp_ary = child_ary; ary_known = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_child_ack", child_ack, model_accepts());
            check("cyc_mutant_valid", mutant_valid, m_out);
            if (ary_known) check("cyc_mutant_ary", mutant_ary, exp_ary);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) rand_data = 16'($urandom);
    endtask

    task automatic send(input string name, input int m, input int num, input int prob);
        tick();
        cnfg_m = 5'(m); cnfg_mut_num = 4'(num); cnfg_mut_prob = 8'(prob);
        child_valid = 1'b1;
        @(negedge clk);
        check({name, "_ack"}, child_ack, 1'b1);
        tick();
        child_valid = 1'b0;
    endtask

    task automatic release_out();
        tick();
        mutant_ack = 1'b1;
        tick();
        mutant_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mutant_valid && n < 40);
        check({name, "_latency"}, n, exp_cyc);
    endtask

    task automatic random_child();
        for (int i = 0; i < 20; i++) child_ary[i] = 8'($urandom);
    endtask

    task automatic single_flip(input string name, input int m, input logic [15:0] rnd,
                               input int elem, input logic [7:0] val);
        logic [19:0][7:0] lit;
        lit = '0;
        lit[elem] = val;
        child_ary = '0;
        rand_data = rnd;
        send(name, m, 1, 255);
        @(negedge clk);
        check({name, "_busy"}, mutant_valid, 1'b0);
        @(negedge clk);
        check({name, "_valid"}, mutant_valid, 1'b1);
        check({name, "_ary"}, mutant_ary, lit);
        release_out();
    endtask

    initial begin
        logic [19:0][7:0] saved;
        logic [19:0][7:0] lit;
        rstn = 1'b1; sw_rst = 1'b0; cnfg_m = 5'd20; cnfg_mut_num = '0; cnfg_mut_prob = '0;
        rand_data = '0; child_valid = 1'b0; child_ary = '0; mutant_ack = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", mutant_valid, 1'b0);
        check("rst_ary", mutant_ary, 160'd0);
        check("rst_ack", child_ack, 1'b0);

        // Pass-through
        for (int i = 0; i < 20; i++) child_ary[i] = 8'(i);
        lit = child_ary;
        send("pt", 20, 0, 0);
        @(negedge clk);
        check("pt_valid", mutant_valid, 1'b1);
        check("pt_ary", mutant_ary, lit);
        release_out();

        // Single flips, wrap and clamp of the element index
        single_flip("flip", 20, 16'h00A3, 3, 8'h20);
        single_flip("wrap", 10, 16'h000D, 3, 8'h01);
        single_flip("clamp", 10, 16'h001F, 9, 8'h01);

        // Zero probability over 15 attempts
        random_child();
        saved = child_ary;
        rand_mode = 1'b1;
        send("p0", 20, 15, 0);
        wait_valid("p0", 16);
        check("p0_ary", mutant_ary, saved);
        release_out();

        // Stall then back-to-back accept
        random_child();
        send("b2b_first", 20, 2, 255);
        wait_valid("b2b_first", 3);
        tick();
        random_child();
        child_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", mutant_valid, 1'b1);
            check("stall_ack", child_ack, 1'b0);
        end
        tick();
        mutant_ack = 1'b1;
        #1 check("b2b_ack", child_ack, 1'b1);
        tick();
        child_valid = 1'b0; mutant_ack = 1'b0;
        wait_valid("b2b_second", 3);
        release_out();

        // Soft reset during attempt 2 of 4
        random_child();
        send("swr", 20, 4, 255);
        tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        @(negedge clk);
        check("swr_valid", mutant_valid, 1'b0);
        check("swr_ary", mutant_ary, 160'd0);
        random_child();
        saved = child_ary;
        send("swr_next", 20, 0, 0);
        @(negedge clk);
        check("swr_next_ary", mutant_ary, saved);
        release_out();

        // Asynchronous reset mid-cycle during attempt 2 of 4
        random_child();
        send("arst", 20, 4, 255);
        tick();
        #5 rstn = 1'b0;
        #1;
        check("arst_valid", mutant_valid, 1'b0);
        check("arst_ary", mutant_ary, 160'd0);
        tick();
        rstn = 1'b1;
        random_child();
        saved = child_ary;
        send("arst_next", 20, 0, 0);
        @(negedge clk);
        check("arst_next_ary", mutant_ary, saved);
        release_out();

        // No active elements: nothing may change
        random_child();
        saved = child_ary;
        send("m0", 0, 15, 255);
        wait_valid("m0", 16);
        check("m0_ary", mutant_ary, saved);
        release_out();

        rand_mode = 1'b0;
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
